// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one result buffer per functional unit, round-robin
// grant of one buffered result per cycle, registered broadcast to all stations.

module cdb_slot #(
   parameter int TAG_W  = 4,
   parameter int DATA_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              load_i,
   input  logic              grant_i,
   input  logic [TAG_W-1:0]  tag_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              vld_o,
   output logic [TAG_W-1:0]  tag_o,
   output logic [DATA_W-1:0] data_o
);
   logic              vld_q;
   logic [TAG_W-1:0]  tag_q;
   logic [DATA_W-1:0] data_q;

   // A refill on the grant edge wins over the clear, so a source sustains 1/cycle.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vld_q  <= 1'b0;
         tag_q  <= '0;
         data_q <= '0;
      end else if (flush_i) begin
         vld_q <= 1'b0;
      end else if (load_i) begin
         vld_q  <= 1'b1;
         tag_q  <= tag_i;
         data_q <= data_i;
      end else if (grant_i) begin
         vld_q <= 1'b0;
      end
   end

   assign vld_o  = vld_q;
   assign tag_o  = tag_q;
   assign data_o = data_q;
endmodule

module cdb_arbiter #(
   parameter int N_SRC  = 4,
   parameter int TAG_W  = 4,
   parameter int DATA_W = 32,
   localparam int SRC_W = $clog2(N_SRC)
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      flush_i,
   input  logic [N_SRC-1:0]          fu_valid_i,
   input  logic [N_SRC*TAG_W-1:0]    fu_tag_i,
   input  logic [N_SRC*DATA_W-1:0]   fu_data_i,
   output logic [N_SRC-1:0]          fu_ready_o,
   output logic                      cdb_valid_o,
   output logic [TAG_W-1:0]          cdb_tag_o,
   output logic [DATA_W-1:0]         cdb_data_o,
   output logic [SRC_W-1:0]          cdb_src_o,
   output logic                      err_tag0_o
);
   logic [N_SRC-1:0]             buf_v, grant, accept, load, tag_zero;
   logic [N_SRC-1:0][TAG_W-1:0]  buf_tag;
   logic [N_SRC-1:0][DATA_W-1:0] buf_data;
   logic [SRC_W-1:0]             ptr_q, ptr_d, gnt_idx, scan_idx;
   logic [SRC_W:0]               scan_sum;
   logic                         gnt_any;
   logic                         cdb_valid_q, err_tag0_q;
   logic [TAG_W-1:0]             cdb_tag_q;
   logic [DATA_W-1:0]            cdb_data_q;
   logic [SRC_W-1:0]             cdb_src_q;

   // Grant looks only at buffer state and pointer, so ready never depends on fu_valid.
   always_comb begin
      grant    = '0;
      gnt_idx  = '0;
      gnt_any  = 1'b0;
      scan_sum = '0;
      scan_idx = '0;
      for (int k = 0; k < N_SRC; k++) begin
         scan_sum = {1'b0, ptr_q} + (SRC_W+1)'(k);
         if (scan_sum >= (SRC_W+1)'(N_SRC)) scan_sum = scan_sum - (SRC_W+1)'(N_SRC);
         scan_idx = scan_sum[SRC_W-1:0];
         if (!gnt_any && buf_v[scan_idx]) begin
            grant[scan_idx] = 1'b1;
            gnt_idx         = scan_idx;
            gnt_any         = 1'b1;
         end
      end
   end

   assign ptr_d      = (gnt_idx == SRC_W'(N_SRC-1)) ? '0 : gnt_idx + SRC_W'(1);
   assign fu_ready_o = flush_i ? '0 : (~buf_v | grant);
   assign accept     = fu_valid_i & fu_ready_o;

   for (genvar i = 0; i < N_SRC; i++) begin : g_src
      logic [TAG_W-1:0] in_tag;
      assign in_tag      = fu_tag_i[i*TAG_W +: TAG_W];
      assign tag_zero[i] = accept[i] & (in_tag == '0);
      assign load[i]     = accept[i] & (in_tag != '0);

      cdb_slot #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_slot (
         .clk_i   (clk_i),
         .rst_i   (rst_i),
         .flush_i (flush_i),
         .load_i  (load[i]),
         .grant_i (grant[i]),
         .tag_i   (in_tag),
         .data_i  (fu_data_i[i*DATA_W +: DATA_W]),
         .vld_o   (buf_v[i]),
         .tag_o   (buf_tag[i]),
         .data_o  (buf_data[i])
      );
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cdb_valid_q <= 1'b0;
         cdb_tag_q   <= '0;
         cdb_data_q  <= '0;
         cdb_src_q   <= '0;
         err_tag0_q  <= 1'b0;
         ptr_q       <= '0;
      end else if (flush_i) begin
         cdb_valid_q <= 1'b0;
         err_tag0_q  <= 1'b0;
      end else begin
         cdb_valid_q <= gnt_any;
         err_tag0_q  <= |tag_zero;
         if (gnt_any) begin
            cdb_tag_q  <= buf_tag[gnt_idx];
            cdb_data_q <= buf_data[gnt_idx];
            cdb_src_q  <= gnt_idx;
            ptr_q      <= ptr_d;
         end
      end
   end

   assign cdb_valid_o = cdb_valid_q;
   assign cdb_tag_o   = cdb_tag_q;
   assign cdb_data_o  = cdb_data_q;
   assign cdb_src_o   = cdb_src_q;
   assign err_tag0_o  = err_tag0_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table, hand sequences for backpressure and
// async reset, then random traffic against an array-based reference model.

module tb_cdb_arbiter;
   localparam int N  = 4;
   localparam int TW = 4;
   localparam int DW = 32;
   localparam int SW = 2;

   logic              clk = 1'b0;
   logic              rst, flush;
   logic [N-1:0]      fu_valid, fu_ready;
   logic [N*TW-1:0]   fu_tag;
   logic [N*DW-1:0]   fu_data;
   logic              cdb_valid, err_tag0;
   logic [TW-1:0]     cdb_tag;
   logic [DW-1:0]     cdb_data;
   logic [SW-1:0]     cdb_src;

   cdb_arbiter #(.N_SRC(N), .TAG_W(TW), .DATA_W(DW)) dut (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .fu_valid_i(fu_valid), .fu_tag_i(fu_tag), .fu_data_i(fu_data),
      .fu_ready_o(fu_ready), .cdb_valid_o(cdb_valid), .cdb_tag_o(cdb_tag),
      .cdb_data_o(cdb_data), .cdb_src_o(cdb_src), .err_tag0_o(err_tag0)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   bit            mv[N];
   logic [TW-1:0] mtag[N];
   logic [DW-1:0] mdata[N];
   int            mptr;
   logic          ecv, eerr;
   logic [TW-1:0] etag;
   logic [DW-1:0] edata;
   int            esrc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // oldest-in-rotation valid entry: smallest circular distance from the pointer
   function automatic int winner();
      int best = -1;
      int bd   = N;
      for (int i = 0; i < N; i++)
         if (mv[i] && ((i - mptr + N) % N) < bd) begin
            bd   = (i - mptr + N) % N;
            best = i;
         end
      return best;
   endfunction

   function automatic logic [N-1:0] mready(input logic fl);
      logic [N-1:0] r = '0;
      int w = winner();
      for (int i = 0; i < N; i++) r[i] = !fl && (!mv[i] || i == w);
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin mv[i] = 0; mtag[i] = '0; mdata[i] = '0; end
      mptr = 0; ecv = 0; eerr = 0; etag = '0; edata = '0; esrc = 0;
   endtask

   task automatic model_edge();
      int w = winner();
      if (flush) begin
         for (int i = 0; i < N; i++) mv[i] = 0;
         ecv = 0; eerr = 0;
      end else begin
         eerr = 0;
         ecv  = (w >= 0);
         if (w >= 0) begin
            etag = mtag[w]; edata = mdata[w]; esrc = w;
            mv[w] = 0; mptr = (w + 1) % N;
         end
         for (int i = 0; i < N; i++)
            if (fu_valid[i] && !mv[i]) begin
               if (fu_tag[i*TW +: TW] == '0) eerr = 1;
               else begin
                  mv[i] = 1; mtag[i] = fu_tag[i*TW +: TW]; mdata[i] = fu_data[i*DW +: DW];
               end
            end
      end
   endtask

   task automatic check_outputs();
      chk("cdb_valid", cdb_valid, ecv);
      chk("cdb_tag", cdb_tag, etag);
      chk("cdb_data", cdb_data, edata);
      chk("cdb_src", cdb_src, esrc);
      chk("err_tag0", err_tag0, eerr);
   endtask

   // Called at posedge+1; drives one cycle, checks ready before the edge, outputs after.
   task automatic step(input logic fl, input logic [N-1:0] v, input logic [N*TW-1:0] t,
                       input logic [N*DW-1:0] d, output logic [N-1:0] rdy_seen);
      flush = fl; fu_valid = v; fu_tag = t; fu_data = d;
      #1;
      rdy_seen = fu_ready;
      chk("fu_ready", fu_ready, mready(fl));
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   typedef struct {
      logic          fl;
      logic [N-1:0]  v;
      logic [N*TW-1:0] t;
      logic [DW-1:0] dbase;
      logic [N-1:0]  rdy;
      logic          cv;
      logic [SW-1:0] src;
      logic [TW-1:0] tag;
      logic [DW-1:0] data;
      logic          err;
   } vec_t;

   function automatic vec_t mk(input logic fl, input logic [N-1:0] v, input logic [N*TW-1:0] t,
                               input logic [DW-1:0] dbase, input logic [N-1:0] rdy, input logic cv,
                               input logic [SW-1:0] src, input logic [TW-1:0] tag,
                               input logic [DW-1:0] data, input logic err);
      vec_t r;
      r.fl = fl; r.v = v; r.t = t; r.dbase = dbase; r.rdy = rdy; r.cv = cv;
      r.src = src; r.tag = tag; r.data = data; r.err = err;
      return r;
   endfunction

   function automatic logic [N*DW-1:0] spread(input logic [DW-1:0] base);
      logic [N*DW-1:0] d;
      for (int i = 0; i < N; i++) d[i*DW +: DW] = base + DW'(i);
      return d;
   endfunction

   vec_t tbl[20];
   logic [N-1:0] rs;
   logic [N*TW-1:0] rt;

   initial begin
      // rotation with all sources valid every cycle, then drain
      tbl[0]  = mk(0, 4'b1111, 16'h4321, 32'h100, 4'b1111, 0, 0, 0, 0, 0);
      tbl[1]  = mk(0, 4'b1111, 16'h4321, 32'h200, 4'b0001, 1, 0, 1, 32'h100, 0);
      tbl[2]  = mk(0, 4'b1111, 16'h4321, 32'h300, 4'b0010, 1, 1, 2, 32'h101, 0);
      tbl[3]  = mk(0, 4'b1111, 16'h4321, 32'h400, 4'b0100, 1, 2, 3, 32'h102, 0);
      tbl[4]  = mk(0, 4'b1111, 16'h4321, 32'h500, 4'b1000, 1, 3, 4, 32'h103, 0);
      tbl[5]  = mk(0, 4'b1111, 16'h4321, 32'h600, 4'b0001, 1, 0, 1, 32'h200, 0);
      tbl[6]  = mk(0, 4'b0000, 16'h0000, 32'h0,   4'b0010, 1, 1, 2, 32'h301, 0);
      tbl[7]  = mk(0, 4'b0000, 16'h0000, 32'h0,   4'b0110, 1, 2, 3, 32'h402, 0);
      tbl[8]  = mk(0, 4'b0000, 16'h0000, 32'h0,   4'b1110, 1, 3, 4, 32'h503, 0);
      tbl[9]  = mk(0, 4'b0000, 16'h0000, 32'h0,   4'b1111, 1, 0, 1, 32'h600, 0);
      tbl[10] = mk(0, 4'b0000, 16'h0000, 32'h0,   4'b1111, 0, 0, 0, 0, 0);
      // single source 2, tag 5
      tbl[11] = mk(0, 4'b0100, 16'h0500, 32'hDEADBEED, 4'b1111, 0, 0, 0, 0, 0);
      tbl[12] = mk(0, 4'b0000, 16'h0000, 32'h0,   4'b1111, 1, 2, 5, 32'hDEADBEEF, 0);
      tbl[13] = mk(0, 4'b0000, 16'h0000, 32'h0,   4'b1111, 0, 0, 0, 0, 0);
      // reserved tag 0 on source 1 with data 0x1234
      tbl[14] = mk(0, 4'b0010, 16'h0000, 32'h1233, 4'b1111, 0, 0, 0, 0, 1);
      tbl[15] = mk(0, 4'b0000, 16'h0000, 32'h0,   4'b1111, 0, 0, 0, 0, 0);
      // fill three buffers, then flush
      tbl[16] = mk(0, 4'b0111, 16'h0987, 32'h700, 4'b1111, 0, 0, 0, 0, 0);
      tbl[17] = mk(1, 4'b1111, 16'hFFFF, 32'h800, 4'b0000, 0, 0, 0, 0, 0);
      tbl[18] = mk(0, 4'b0000, 16'h0000, 32'h0,   4'b1111, 0, 0, 0, 0, 0);
      tbl[19] = mk(0, 4'b0000, 16'h0000, 32'h0,   4'b1111, 0, 0, 0, 0, 0);

      rst = 1'b1; flush = 1'b0; fu_valid = '0; fu_tag = '0; fu_data = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs();
      rst = 1'b0;

      for (int r = 0; r < 20; r++) begin
         step(tbl[r].fl, tbl[r].v, tbl[r].t, spread(tbl[r].dbase), rs);
         chk($sformatf("tbl%0d ready", r), rs, tbl[r].rdy);
         chk($sformatf("tbl%0d valid", r), cdb_valid, tbl[r].cv);
         chk($sformatf("tbl%0d err", r), err_tag0, tbl[r].err);
         if (tbl[r].cv) begin
            chk($sformatf("tbl%0d src", r), cdb_src, tbl[r].src);
            chk($sformatf("tbl%0d tag", r), cdb_tag, tbl[r].tag);
            chk($sformatf("tbl%0d data", r), cdb_data, tbl[r].data);
         end
      end

      // backpressure: move pointer to 1, buffer sources 0 and 1, keep source 0 pushing tag 3
      step(0, 4'b0001, 16'h0006, spread(32'hA00), rs);
      step(0, 4'b0000, 16'h0000, spread(32'h0), rs);
      chk("bp ptr setup src", cdb_src, 0);
      step(0, 4'b0011, 16'h0021, spread(32'hB00), rs);
      step(0, 4'b0001, 16'h0003, spread(32'hC00), rs);
      chk("bp src0 blocked", rs[0], 1'b0);
      chk("bp first grant src", cdb_src, 1);
      step(0, 4'b0001, 16'h0003, spread(32'hC00), rs);
      chk("bp src0 accepted", rs[0], 1'b1);
      chk("bp second grant tag", cdb_tag, 1);
      step(0, 4'b0000, 16'h0000, spread(32'h0), rs);
      chk("bp new result tag", cdb_tag, 3);
      chk("bp new result data", cdb_data, 32'hC00);
      step(0, 4'b0000, 16'h0000, spread(32'h0), rs);
      chk("bp no duplicate", cdb_valid, 1'b0);

      // async reset in the middle of a burst
      for (int c = 0; c < 3; c++) step(0, 4'b1111, 16'h8765, spread(32'hE00), rs);
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      check_outputs();
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(0, 4'b1010, 16'h9090, spread(32'hF00), rs);
      chk("rst ready all ones", rs, 4'b1111);
      step(0, 4'b0000, 16'h0000, spread(32'h0), rs);
      chk("rst first grant lowest", cdb_src, 1);

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++)
            rt[i*TW +: TW] = ($urandom_range(0, 7) == 0) ? '0 : TW'($urandom_range(1, 15));
         step($urandom_range(0, 15) == 0, N'($urandom), rt,
              {$urandom, $urandom, $urandom, $urandom}, rs);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
